ram_port_arbiter: RTL

- Two-requester arbiter that shares the single-port word RAM (byte write enables, combinational read, data shifted by addr[1:0]) between master 0 (CPU load/store unit) and master 1 (debug/DMA loader).
- Grants one request per cycle with round-robin fairness.
- Supports a bounded lock so a master can hold consecutive cycles.
- Returns read data registered, one cycle after grant.

---
 rtl/ram_port_arbiter_pkg.sv | 16 +
 rtl/ram_port_arbiter_if.sv | 22 ++
 rtl/ram_port_arbiter_rr_lock_arbiter2.sv | 77 +++++++
 rtl/ram_port_arbiter.sv | 75 +++++++
 4 files changed

// File: rtl/ram_port_arbiter_pkg.sv
// Shared definitions for the two-master RAM port arbiter: master indices and
// the lock-state encoding.
package ram_port_arbiter_pkg;

  localparam logic M_CPU = 1'b0;
  localparam logic M_DBG = 1'b1;

  localparam logic [1:0] LK_NONE = 2'd0;
  localparam logic [1:0] LK_M0   = 2'd1;
  localparam logic [1:0] LK_M1   = 2'd2;

  function automatic logic [1:0] lk_of(input logic idx);
    return idx ? LK_M1 : LK_M0;
  endfunction

endpackage

// File: rtl/ram_port_arbiter_if.sv
// One requester port of the RAM arbiter: request/lock/bus in, grant and
// registered read response out.
interface ram_port_arbiter_if;
  logic        req;
  logic        lock;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  wenable;
  logic        gnt;
  logic        rvalid;
  logic [31:0] rdata;

  modport master (
    output req, lock, addr, wdata, wenable,
    input  gnt, rvalid, rdata
  );

  modport slave (
    input  req, lock, addr, wdata, wenable,
    output gnt, rvalid, rdata
  );
endinterface

// File: rtl/ram_port_arbiter_rr_lock_arbiter2.sv
// Round-robin grant for two requesters with a bounded lock that lets one
// master keep the port for up to MAX_LOCK consecutive cycles.
//
// state   | meaning
// LK_NONE | no owner, plain round-robin between requesters
// LK_M0   | master 0 holds the lock, r_lock_cnt = cycles granted so far
// LK_M1   | master 1 holds the lock, r_lock_cnt = cycles granted so far
module rr_lock_arbiter2
  import ram_port_arbiter_pkg::*;
#(
  parameter int MAX_LOCK = 8,
  parameter int LOCK_W   = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] i_req,
  input  logic [1:0] i_lock,
  output logic [1:0] o_gnt
);

  localparam logic [LOCK_W-1:0] CNT_MAX = LOCK_W'(MAX_LOCK);

  logic              r_last_grant;
  logic [1:0]        r_lock_state;
  logic [LOCK_W-1:0] r_lock_cnt;

  logic       w_locked;
  logic       w_owner;
  logic       w_at_max;
  logic       w_handover;
  logic       w_gidx;
  logic [1:0] w_gnt;

  always_comb begin
    w_locked   = (r_lock_state != LK_NONE);
    w_owner    = (r_lock_state == LK_M1);
    w_at_max   = (r_lock_cnt >= CNT_MAX);
    w_handover = w_locked && w_at_max && (&i_req);
    w_gnt      = 2'b00;
    if (w_locked && i_req[w_owner] && !w_at_max)
      w_gnt[w_owner] = 1'b1;
    else if (i_req == 2'b01)
      w_gnt = 2'b01;
    else if (i_req == 2'b10)
      w_gnt = 2'b10;
    else if (i_req == 2'b11)
      w_gnt = (r_last_grant == M_CPU) ? 2'b10 : 2'b01;
    w_gidx = w_gnt[1];
  end

  assign o_gnt = rst ? 2'b00 : w_gnt;

  // A forced hand-over always drops to LK_NONE, whatever lock the grantee asks for.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_last_grant <= M_DBG;
      r_lock_state <= LK_NONE;
      r_lock_cnt   <= '0;
    end else if (w_gnt == 2'b00) begin
      r_lock_state <= LK_NONE;
      r_lock_cnt   <= '0;
    end else begin
      r_last_grant <= w_gidx;
      if (w_handover || !i_lock[w_gidx]) begin
        r_lock_state <= LK_NONE;
        r_lock_cnt   <= '0;
      end else if (r_lock_state == lk_of(w_gidx)) begin
        if (!w_at_max)
          r_lock_cnt <= r_lock_cnt + LOCK_W'(1);
      end else begin
        r_lock_state <= lk_of(w_gidx);
        r_lock_cnt   <= LOCK_W'(1);
      end
    end
  end

endmodule

// File: rtl/ram_port_arbiter.sv
// Shares one single-port word RAM between the CPU and the debug/DMA loader:
// steers the granted master onto the RAM bus and registers its read response.
module ram_port_arbiter
  import ram_port_arbiter_pkg::*;
#(
  parameter int MAX_LOCK = 8,
  parameter int LOCK_W   = 8
) (
  input  logic                clk,
  input  logic                rst,
  ram_port_arbiter_if.slave   m0,
  ram_port_arbiter_if.slave   m1,
  output logic [31:0]         ram_addr,
  output logic [31:0]         ram_wdata,
  output logic [3:0]          ram_wenable,
  input  logic [31:0]         ram_rdata
);

  logic [1:0]  w_gnt;
  logic        r_rvalid0;
  logic        r_rvalid1;
  logic [31:0] r_rdata0;
  logic [31:0] r_rdata1;

  rr_lock_arbiter2 #(
    .MAX_LOCK (MAX_LOCK),
    .LOCK_W   (LOCK_W)
  ) u_arb (
    .clk    (clk),
    .rst    (rst),
    .i_req  ({m1.req,  m0.req}),
    .i_lock ({m1.lock, m0.lock}),
    .o_gnt  (w_gnt)
  );

  // Master 0 drives the bus whenever master 1 is not granted, so idle cycles are deterministic.
  always_comb begin
    ram_addr    = m0.addr;
    ram_wdata   = m0.wdata;
    ram_wenable = w_gnt[M_CPU] ? m0.wenable : 4'b0000;
    if (rst) begin
      ram_addr    = '0;
      ram_wdata   = '0;
      ram_wenable = 4'b0000;
    end else if (w_gnt[M_DBG]) begin
      ram_addr    = m1.addr;
      ram_wdata   = m1.wdata;
      ram_wenable = m1.wenable;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rvalid0 <= 1'b0;
      r_rvalid1 <= 1'b0;
      r_rdata0  <= '0;
      r_rdata1  <= '0;
    end else begin
      r_rvalid0 <= w_gnt[M_CPU];
      r_rvalid1 <= w_gnt[M_DBG];
      if (w_gnt[M_CPU])
        r_rdata0 <= ram_rdata;
      if (w_gnt[M_DBG])
        r_rdata1 <= ram_rdata;
    end
  end

  assign m0.gnt    = w_gnt[M_CPU];
  assign m1.gnt    = w_gnt[M_DBG];
  assign m0.rvalid = r_rvalid0;
  assign m1.rvalid = r_rvalid1;
  assign m0.rdata  = r_rdata0;
  assign m1.rdata  = r_rdata1;

endmodule
